// File: rtl/buf_sequencer_if.sv
// Handshake and buffer-control bundle between the job controller/loader and buf_sequencer.
// master drives job control and loader data; slave is the sequencer itself.
interface buf_sequencer_if #(
  parameter int LOG_DEPTH = 5,
  parameter int TILE_W    = 16
);
  logic                 start;
  logic [TILE_W-1:0]    num_tiles;
  logic [LOG_DEPTH-1:0] tile_len;
  logic                 ld_valid;
  logic                 ld_ready;
  logic                 buf_we;
  logic [LOG_DEPTH:0]   buf_waddr;
  logic                 buf_re;
  logic [LOG_DEPTH:0]   buf_raddr;
  logic                 obuf_we;
  logic [LOG_DEPTH-1:0] obuf_waddr;
  logic                 busy;
  logic                 done;
  logic [63:0]          cycle_count;

  modport master (
    output start, num_tiles, tile_len, ld_valid,
    input  ld_ready, buf_we, buf_waddr, buf_re, buf_raddr,
           obuf_we, obuf_waddr, busy, done, cycle_count
  );

  modport slave (
    input  start, num_tiles, tile_len, ld_valid,
    output ld_ready, buf_we, buf_waddr, buf_re, buf_raddr,
           obuf_we, obuf_waddr, busy, done, cycle_count
  );
endinterface

// File: rtl/buf_sequencer.sv
// Ping-pong ibuf/wbuf sequencer: loader fills one bank while the array drains the other,
// array results are tracked through a PIPE_LAT delay line into obuf.
module buf_sequencer #(
  parameter int LOG_DEPTH = 5,
  parameter int PIPE_LAT  = 16,
  parameter int TILE_W    = 16
) (
  input logic            clk,
  input logic            rst,
  buf_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]           full_q, full_d;
  logic [TILE_W-1:0]    tiles_loaded_q, tiles_loaded_d;
  logic [TILE_W-1:0]    tiles_done_q, tiles_done_d;
  logic [TILE_W-1:0]    num_tiles_q, num_tiles_d;
  logic [LOG_DEPTH:0]   len_q, len_d;
  logic [LOG_DEPTH-1:0] obuf_waddr_q, obuf_waddr_d;
  logic [63:0]          cycle_count_q, cycle_count_d;
  logic [PIPE_LAT-1:0]  pipe_q, pipe_d;

  logic               ld_ready, wr_fire, rd_fire, wr_last, rd_last;
  logic [LOG_DEPTH:0] last_idx;

  assign ld_ready = (state_q == COMPUTE) && !full_q[wr_bank_q] && (tiles_loaded_q < num_tiles_q);
  assign wr_fire  = ld_ready && bus.ld_valid;
  assign rd_fire  = (state_q == COMPUTE) && full_q[rd_bank_q];
  assign last_idx = len_q - (LOG_DEPTH+1)'(1);
  assign wr_last  = ({1'b0, wr_ptr_q} == last_idx);
  assign rd_last  = ({1'b0, rd_ptr_q} == last_idx);

  // Delay line shifts toward the MSB; the MSB is the obuf write strobe.
  if (PIPE_LAT == 1) begin : g_pipe1
    assign pipe_d = rd_fire;
  end else begin : g_pipen
    assign pipe_d = {pipe_q[PIPE_LAT-2:0], rd_fire};
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    full_d         = full_q;
    tiles_loaded_d = tiles_loaded_q;
    tiles_done_d   = tiles_done_q;
    num_tiles_d    = num_tiles_q;
    len_d          = len_q;
    obuf_waddr_d   = obuf_waddr_q;
    cycle_count_d  = cycle_count_q;

    if (state_q != IDLE) cycle_count_d = cycle_count_q + 64'd1;

    if (wr_fire) begin
      if (wr_last) begin
        wr_ptr_d          = '0;
        wr_bank_d         = !wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
        tiles_loaded_d    = tiles_loaded_q + TILE_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
      end
    end

    // Reader always holds a full bank, loader an empty one, so these never touch the same flag.
    if (rd_fire) begin
      if (rd_last) begin
        rd_ptr_d          = '0;
        rd_bank_d         = !rd_bank_q;
        full_d[rd_bank_q] = 1'b0;
        tiles_done_d      = tiles_done_q + TILE_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
      end
    end

    if (pipe_q[PIPE_LAT-1]) obuf_waddr_d = obuf_waddr_q + LOG_DEPTH'(1);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          wr_ptr_d       = '0;
          rd_ptr_d       = '0;
          wr_bank_d      = 1'b0;
          rd_bank_d      = 1'b0;
          full_d         = '0;
          tiles_loaded_d = '0;
          tiles_done_d   = '0;
          obuf_waddr_d   = '0;
          cycle_count_d  = '0;
          num_tiles_d    = bus.num_tiles;
          len_d          = (bus.tile_len == '0) ? {1'b1, {LOG_DEPTH{1'b0}}} : {1'b0, bus.tile_len};
          state_d        = (bus.num_tiles == '0) ? DONE : COMPUTE;
        end
      end
      COMPUTE: if (tiles_done_q == num_tiles_q) state_d = FLUSH;
      FLUSH:   if (pipe_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      full_q         <= '0;
      tiles_loaded_q <= '0;
      tiles_done_q   <= '0;
      num_tiles_q    <= '0;
      len_q          <= '0;
      obuf_waddr_q   <= '0;
      cycle_count_q  <= '0;
      pipe_q         <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      full_q         <= full_d;
      tiles_loaded_q <= tiles_loaded_d;
      tiles_done_q   <= tiles_done_d;
      num_tiles_q    <= num_tiles_d;
      len_q          <= len_d;
      obuf_waddr_q   <= obuf_waddr_d;
      cycle_count_q  <= cycle_count_d;
      pipe_q         <= pipe_d;
    end
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.buf_we      = wr_fire;
  assign bus.buf_waddr   = {wr_bank_q, wr_ptr_q};
  assign bus.buf_re      = rd_fire;
  assign bus.buf_raddr   = {rd_bank_q, rd_ptr_q};
  assign bus.obuf_we     = pipe_q[PIPE_LAT-1];
  assign bus.obuf_waddr  = obuf_waddr_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: doc/buf_sequencer.md
BUF_SEQUENCER -- requirements
Module: buf_sequencer

Interface
REQ-001 Parameter LOG_DEPTH, default 5: per-bank buffer depth is 2^LOG_DEPTH vectors; buffers hold 2 banks (ping-pong).
REQ-002 Parameter PIPE_LAT, default 16: cycles from a buffer read to the matching array result entering obuf.
REQ-003 Parameter TILE_W, default 16: width of the num_tiles and tile counters.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  asynchronous, active-low reset; asserted when 0.
REQ-006 start  in  1  one-cycle pulse that launches a job; sampled only in IDLE.
REQ-007 num_tiles  in  TILE_W  tiles in the job; sampled on accepted start.
REQ-008 tile_len  in  LOG_DEPTH  vectors per tile; 0 means 2^LOG_DEPTH; sampled on accepted start.
REQ-009 ld_valid  in  1  loader has an input/weight vector for the buffers.
REQ-010 ld_ready  out  1  sequencer accepts the vector this cycle.
REQ-011 buf_we  out  1  write strobe to ibuf/wbuf.
REQ-012 buf_waddr  out  LOG_DEPTH+1  write address; MSB selects the bank.
REQ-013 buf_re  out  1  read strobe to ibuf/wbuf feeding the systolic array.
REQ-014 buf_raddr  out  LOG_DEPTH+1  read address; MSB selects the bank.
REQ-015 obuf_we  out  1  obuf write strobe.
REQ-016 obuf_waddr  out  LOG_DEPTH  obuf write address.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 cycle_count  out  64  clocks spent busy in the current or most recent job.

Function
REQ-020 The FSM SHALL have states IDLE, COMPUTE, FLUSH and DONE; start in IDLE goes to COMPUTE, or to DONE when num_tiles==0.
REQ-021 A start seen outside IDLE SHALL be ignored.
REQ-022 On an accepted start, the block SHALL clear to 0 all of: write/read pointers, wr_bank, rd_bank, bank-full flags, tile counters, obuf_waddr and cycle_count.
REQ-023 Loader: ld_ready = (state==COMPUTE) & !full[wr_bank] & (tiles_loaded<num_tiles).
REQ-024 Loader handshake: on ld_valid&ld_ready the block SHALL drive buf_we=1 and buf_waddr={wr_bank,wr_ptr} in the same cycle, then increment wr_ptr.
REQ-025 When wr_ptr==len-1 on a handshake, the block SHALL set full[wr_bank] next cycle, reset wr_ptr to 0, toggle wr_bank and increment tiles_loaded.
REQ-026 Compute: while in COMPUTE with full[rd_bank]==1, the block SHALL drive buf_re=1 and buf_raddr={rd_bank,rd_ptr} and increment rd_ptr each cycle, with no gaps within a tile.
REQ-027 On the last read of a tile, the block SHALL clear full[rd_bank] next cycle, toggle rd_bank and increment tiles_done.
REQ-028 A flag set/clear SHALL be visible to ld_ready/buf_re one cycle later; loader and reader never address the same bank in the same cycle.
REQ-029 obuf_we SHALL equal buf_re delayed exactly PIPE_LAT cycles (shift register); obuf_waddr increments after each obuf_we and wraps 2^LOG_DEPTH-1 -> 0.
REQ-030 When tiles_done reaches num_tiles, COMPUTE SHALL go to FLUSH; FLUSH waits until the delay line is empty, then goes to DONE.
REQ-031 DONE SHALL assert done for one cycle and go to IDLE.
REQ-032 cycle_count SHALL increment in every non-IDLE cycle, hold in IDLE, and clear only on an accepted start or reset.

Reset
REQ-033 rst==0 SHALL immediately force: state IDLE; all outputs 0; flags, pointers, counters and delay line 0 — including mid-job.
REQ-034 After rst returns high, the next start SHALL run a full job correctly.

Verification
REQ-035 num_tiles=2, tile_len=4, ld_valid=1 -> waddr 0,1,2,3,32,33,34,35; raddr 0..3 starting 1 cycle after the bank-0 fill completes, then 32..35; obuf_waddr 0..7; exactly one done pulse.
REQ-036 num_tiles=4, tile_len=4, ld_valid=1, reads continuous -> after two fills, ld_ready=0 until bank 0 is freed; no write ever hits a full bank.
REQ-037 tile_len=0, num_tiles=1 -> 32 writes (addr 0..31), then 32 reads, then 32 obuf writes.
REQ-038 num_tiles=3, tile_len=16 -> 48 obuf writes; obuf_waddr wraps 31->0 and ends at 15.
REQ-039 num_tiles=0 -> done one cycle after start; buf_we, buf_re and obuf_we never assert; cycle_count=1.
REQ-040 rst pulsed low mid-COMPUTE -> busy, buf_re and obuf_we at 0 with no clock edge; a start during busy is ignored; restart with num_tiles=1, tile_len=2 -> 2 obuf writes at addresses 0 and 1.
